// File: rtl/sync_filter.sv
`default_nettype none
// ============================================================================
// Module   : sync_filter
// Brief    : Multi-channel async-input synchronizer with a per-channel
//            stability filter, edge strobes and sticky glitch flags.
// Revision : 1.0
// ============================================================================
module sync_filter #(
    parameter int   WIDTH      = 1,
    parameter int   FF_NUM     = 2,
    parameter int   FILTER_LEN = 4,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] signal_in,
    input  logic             glitch_clr,
    output logic [WIDTH-1:0] signal_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] glitch
);

    localparam int c_DEPTH = (FF_NUM < 2) ? 2 : FF_NUM;
    localparam int c_CNT_W = $clog2(FILTER_LEN + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(FILTER_LEN - 1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [c_DEPTH-1:0] r_sync;
        logic [c_CNT_W-1:0] r_cnt;
        logic               r_out;
        logic               r_rise;
        logic               r_fall;
        logic               r_glitch;
        logic               w_s;
        logic               w_same;
        logic               w_accept;

        assign w_s      = r_sync[c_DEPTH-1];
        assign w_same   = (w_s == r_out);
        assign w_accept = !w_same && (r_cnt == c_CNT_LAST);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_sync <= {c_DEPTH{IDLE_LEVEL}};
            end else begin
                r_sync <= {r_sync[c_DEPTH-2:0], signal_in[i]};
            end
        end

        // A new level must be seen FILTER_LEN consecutive edges before it is
        // adopted; returning early to the old level marks a rejected pulse.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_cnt    <= '0;
                r_out    <= IDLE_LEVEL;
                r_rise   <= 1'b0;
                r_fall   <= 1'b0;
                r_glitch <= 1'b0;
            end else begin
                r_rise   <= w_accept &&  w_s;
                r_fall   <= w_accept && !w_s;
                r_glitch <= (w_same && (r_cnt != '0)) || (r_glitch && !glitch_clr);
                if (w_same || w_accept) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                if (w_accept) begin
                    r_out <= w_s;
                end
            end
        end

        assign signal_out[i] = r_out;
        assign rise[i]       = r_rise;
        assign fall[i]       = r_fall;
        assign glitch[i]     = r_glitch;
    end

endmodule
`default_nettype wire

// File: tb/tb_sync_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_filter
// Brief    : Directed self-checking bench for sync_filter (default, FF_NUM=1
//            and FILTER_LEN=1 instances driven side by side).
// Revision : 1.0
// ============================================================================
module tb_sync_filter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       glitch_clr = 1'b0;

    logic [7:0] in0 = 8'h00;
    logic [7:0] out0, rise0, fall0, glitch0;
    logic [0:0] in1 = 1'b0;
    logic [0:0] out1, rise1, fall1, glitch1;
    logic [0:0] in2 = 1'b0;
    logic [0:0] out2, rise2, fall2, glitch2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sync_filter #(.WIDTH(8)) u_dut0 (
        .clk(clk), .reset(reset), .signal_in(in0), .glitch_clr(glitch_clr),
        .signal_out(out0), .rise(rise0), .fall(fall0), .glitch(glitch0)
    );

    sync_filter #(.WIDTH(1), .FF_NUM(1)) u_dut1 (
        .clk(clk), .reset(reset), .signal_in(in1), .glitch_clr(glitch_clr),
        .signal_out(out1), .rise(rise1), .fall(fall1), .glitch(glitch1)
    );

    sync_filter #(.WIDTH(1), .FILTER_LEN(1)) u_dut2 (
        .clk(clk), .reset(reset), .signal_in(in2), .glitch_clr(glitch_clr),
        .signal_out(out2), .rise(rise2), .fall(fall2), .glitch(glitch2)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held with inputs low: outputs sit at idle level.
        tick(3);
        check("rst_out0", {24'h0, out0}, 32'hFF);
        check("rst_strb0", {16'h0, rise0, fall0}, 32'h0);
        check("rst_glitch0", {24'h0, glitch0}, 32'h0);
        check("rst_out12", {30'h0, out1, out2}, 32'h3);

        // Release with inputs low: FILTER_LEN=1 falls on edge 3, others on edge 6.
        reset = 1'b0;
        tick(2);
        check("lat2_pre", {30'h0, out2, fall2}, 32'h2);
        tick(1);
        check("lat2_fall", {29'h0, out2, fall2, rise2}, 32'h2);
        tick(2);
        check("lat_pre_out0", {24'h0, out0}, 32'hFF);
        check("lat_pre_fall0", {24'h0, fall0}, 32'h0);
        check("lat_pre_out1", {31'h0, out1}, 32'h1);
        tick(1);
        check("lat_out0", {24'h0, out0}, 32'h00);
        check("lat_fall0", {16'h0, fall0, rise0}, 32'hFF00);
        check("lat1_fall", {29'h0, out1, fall1, rise1}, 32'h2);
        tick(1);
        check("lat_fall0_1cyc", {24'h0, fall0}, 32'h0);

        // Step back high: rise after the same latencies.
        in0 = 8'hFF; in1 = 1'b1; in2 = 1'b1;
        tick(3);
        check("lat2_rise", {29'h0, out2, rise2, fall2}, 32'h6);
        tick(2);
        check("rise_pre_out0", {24'h0, out0}, 32'h00);
        check("rise_pre_rise0", {24'h0, rise0}, 32'h0);
        tick(1);
        check("rise_out0", {24'h0, out0}, 32'hFF);
        check("rise_strb0", {16'h0, rise0, fall0}, 32'hFF00);
        check("lat1_rise", {29'h0, out1, rise1, fall1}, 32'h6);
        tick(1);
        check("rise_1cyc", {16'h0, rise0, fall0}, 32'h0);
        tick(4);
        check("idle_glitch", {24'h0, glitch0}, 32'h0);

        // 3-cycle low pulse on bit 0 is rejected; glitch sets on edge 6.
        in0 = 8'hFE;
        tick(3);
        in0 = 8'hFF;
        tick(2);
        check("rej_glitch_pre", {24'h0, glitch0}, 32'h0);
        check("rej_strb_pre", {8'h0, out0, rise0, fall0}, 32'hFF0000);
        tick(1);
        check("rej_glitch", {24'h0, glitch0}, 32'h01);
        check("rej_out", {8'h0, out0, rise0, fall0}, 32'hFF0000);
        tick(3);
        check("rej_sticky", {24'h0, glitch0}, 32'h01);

        glitch_clr = 1'b1;
        tick(1);
        glitch_clr = 1'b0;
        check("clr", {24'h0, glitch0}, 32'h0);

        // 4-cycle low pulse on bit 1 is accepted: fall edge 6, rise edge 10.
        in0 = 8'hFD;
        tick(4);
        in0 = 8'hFF;
        tick(2);
        check("acc_fall", {8'h0, out0, fall0, rise0}, 32'hFD0200);
        tick(3);
        check("acc_mid", {8'h0, out0, fall0, rise0}, 32'hFD0000);
        tick(1);
        check("acc_rise", {8'h0, out0, rise0, fall0}, 32'hFF0200);
        check("acc_glitch", {24'h0, glitch0}, 32'h0);

        // Clear coinciding with a new set edge: set wins.
        in0 = 8'hFB;
        tick(3);
        in0 = 8'hFF;
        tick(2);
        glitch_clr = 1'b1;
        tick(1);
        glitch_clr = 1'b0;
        check("race_set_wins", {24'h0, glitch0}, 32'h04);
        glitch_clr = 1'b1;
        tick(1);
        glitch_clr = 1'b0;
        check("race_clr", {24'h0, glitch0}, 32'h0);

        // Bit 0 low 2 cycles (rejected), bit 7 low 5 cycles (accepted).
        in0 = 8'h7E;
        tick(2);
        in0 = 8'h7F;
        tick(3);
        in0 = 8'hFF;
        check("ind_glitch", {24'h0, glitch0}, 32'h01);
        check("ind_out_pre", {24'h0, out0}, 32'hFF);
        tick(1);
        check("ind_fall", {8'h0, out0, fall0, rise0}, 32'h7F8000);
        tick(4);
        check("ind_mid", {8'h0, out0, fall0, rise0}, 32'h7F0000);
        tick(1);
        check("ind_rise", {8'h0, out0, rise0, fall0}, 32'hFF8000);
        check("ind_glitch_end", {24'h0, glitch0}, 32'h01);
        glitch_clr = 1'b1;
        tick(1);
        glitch_clr = 1'b0;

        // FILTER_LEN=1 passes a 1-cycle pulse as fall then rise.
        in2 = 1'b0;
        tick(1);
        in2 = 1'b1;
        tick(2);
        check("fl1_fall", {29'h0, out2, fall2, rise2}, 32'h2);
        tick(1);
        check("fl1_rise", {29'h0, out2, rise2, fall2}, 32'h6);
        check("fl1_glitch", {31'h0, glitch2}, 32'h0);

        // Reset mid-transition aborts the pending fall.
        in0 = 8'h00;
        tick(4);
        reset = 1'b1;
        in0 = 8'hFF;
        tick(1);
        check("midrst_out", {8'h0, out0, rise0, fall0}, 32'hFF0000);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            check("midrst_quiet", {out0, rise0, fall0, glitch0}, 32'hFF000000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_filter.md
# sync_filter

Parametrised multi-channel successor to the single-bit synchronizer. It brings WIDTH asynchronous inputs into the `clk` domain through an FF_NUM-deep flop chain per channel. A per-channel stability filter then rejects pulses shorter than FILTER_LEN cycles. It emits the filtered level plus one-cycle rise/fall strobes and sticky glitch flags. It sits between the UART RX pin (and other slow external inputs) and the receiver logic.

## Interface
- `WIDTH`, 1: number of independent channels.
- `FF_NUM`, 2: synchronizer depth per channel; values < 2 are built as 2.
- `FILTER_LEN`, 4: consecutive cycles a new synchronized level must hold before `signal_out` adopts it; must be ≥ 1 (1 = no filtering).
- `IDLE_LEVEL`, 1'b1: reset value of every sync flop and every `signal_out` bit (UART idle high).

- `clk`  input  1  single clock; all state on rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `signal_in`  input  WIDTH  asynchronous raw inputs.
- `glitch_clr`  input  1  synchronous clear of all `glitch` bits.
- `signal_out`  output  WIDTH  synchronized, filtered level.
- `rise`  output  WIDTH  one-cycle strobe when `signal_out[i]` goes 0→1.
- `fall`  output  WIDTH  one-cycle strobe when `signal_out[i]` goes 1→0.
- `glitch`  output  WIDTH  sticky: channel saw a rejected pulse.

## Operation
- Reset (async assert, released synchronously by the system):
  - all sync flops = IDLE_LEVEL, `signal_out` = {WIDTH{IDLE_LEVEL}};
  - `rise` = `fall` = 0, `glitch` = 0, filter counters = 0.
  - Reset mid-operation aborts any pending transition; no strobe is emitted.
- Per channel i, `s` = last sync flop. Channels are fully independent.
- Filter counter `cnt`, width $clog2(FILTER_LEN+1). Each edge:
  - `s == signal_out[i]`: `cnt` ← 0. If `cnt` was nonzero, set `glitch[i]`.
  - `s != signal_out[i]` and `cnt == FILTER_LEN-1`: `signal_out[i]` ← `s`, `cnt` ← 0, and assert `rise[i]` or `fall[i]` for this one cycle.
  - Otherwise: `cnt` ← `cnt`+1.
- `rise`/`fall` are registered, high exactly one cycle per accepted transition, and never both high on one channel.
- `glitch[i]`:
  - cleared by `glitch_clr` on the next edge;
  - if set and clear coincide on an edge, set wins (bit reads 1);
  - `glitch_clr` clears all channels.
- FILTER_LEN=1: `cnt` stays 0, every change is accepted after one cycle, and `glitch` never sets.

## Timing
- Latency: `signal_in[i]` changes before edge 1 and stays stable. Then `signal_out[i]` and the strobe update on edge FF_NUM+FILTER_LEN. Defaults: 6 cycles.
- Rejection: a change visible at `s` for fewer than FILTER_LEN consecutive cycles never reaches `signal_out`.
- Minimum accepted pulse at `s` is FILTER_LEN cycles. Back-to-back accepted transitions are spaced ≥ FILTER_LEN cycles.
- Pin-to-`s` delay is FF_NUM cycles, ±1 cycle of metastability resolution uncertainty. Benches must tolerate this on true async stimulus.
- No combinational path from any input to any output.

## Test plan
- Reset: hold `reset`=1 with `signal_in`=0 (WIDTH=4). Required: `signal_out`=4'hF, `rise`=`fall`=`glitch`=0 throughout; no `fall` strobe on deassert until 6 cycles after release.
- Latency (defaults, WIDTH=1): step `signal_in` 1→0 before edge 1. Required: `signal_out` falls on edge 6, `fall`=1 for exactly that cycle, `rise` stays 0. Step back to 1: `rise` pulses 6 edges later.
- Glitch reject: 3-cycle low pulse on `signal_in` (FILTER_LEN=4). Required: `signal_out` stays 1, no strobes, `glitch`=1 from edge FF_NUM+4. Same with a 4-cycle pulse: accepted, `fall` then `rise` strobes 4 cycles apart, `glitch` stays 0.
- Glitch clear race: with `glitch`=1, pulse `glitch_clr` on a cycle with no new glitch. Required: `glitch`=0 next cycle. Repeat with `glitch_clr` coinciding with a new rejected pulse's set edge. Required: `glitch` remains 1.
- Channel independence (WIDTH=8): toggle bits 0 and 7 with different pulse lengths (2 and 5 cycles) simultaneously. Required: only bit 7 transitions and strobes; only bit 0 sets `glitch`; bits 1–6 unchanged.
- Parameter corners: FF_NUM=1 gives latency 2+FILTER_LEN. FILTER_LEN=1 gives latency FF_NUM+1, and a 1-cycle pulse is passed with `fall`/`rise` on consecutive cycles.
